// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rf_pkg : shared types and constants for the register-file writeback path
// Rev 1.0
// ============================================================================
package rf_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_src_e;

   typedef enum logic {ALU_PRIO = 1'b0, MEM_PRIO = 1'b1} arb_state_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// rf_write_arbiter : shares the RF write port between ALU and mem writeback,
// ALU priority with a starvation guard; x0 writes are sunk without the port.
// Rev 1.0
// ============================================================================
module rf_write_arbiter #(
   parameter int unsigned XLEN       = rf_pkg::XLEN,
   parameter int unsigned REG_ADDR_W = rf_pkg::REG_ADDR_W,
   parameter int unsigned MAX_WAIT   = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_addr,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]       mem_data,
   output logic                  rf_write_en,
   output logic [REG_ADDR_W-1:0] rf_addr,
   output logic [XLEN-1:0]       rf_write_data,
   output logic                  rf_src,
   output logic [CNT_W-1:0]      conflict_cnt
);
   import rf_pkg::*;

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   arb_state_e            state_q;
   logic [WAIT_W-1:0]     wait_cnt_q;
   logic [CNT_W-1:0]      conflict_q;
   logic                  wen_q;
   logic [REG_ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]       data_q;
   wb_src_e               src_q;

   logic w_alu_nz, w_mem_nz, w_compete, w_alu_grant, w_mem_grant, w_mem_starve;

   always_comb begin
      w_alu_nz     = alu_valid && (alu_addr != '0);
      w_mem_nz     = mem_valid && (mem_addr != '0);
      w_compete    = w_alu_nz && w_mem_nz;
      w_alu_grant  = w_alu_nz && (!w_mem_nz || (state_q == ALU_PRIO));
      w_mem_grant  = w_mem_nz && (!w_alu_nz || (state_q == MEM_PRIO));
      w_mem_starve = w_mem_nz && !w_mem_grant;
      // x0 requests are sunk immediately, independent of arbitration
      alu_ready    = !rst && alu_valid && ((alu_addr == '0) || w_alu_grant);
      mem_ready    = !rst && mem_valid && ((mem_addr == '0) || w_mem_grant);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ALU_PRIO;
         wait_cnt_q <= '0;
         conflict_q <= '0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         src_q      <= WB_ALU;
      end else begin
         case (state_q)
            ALU_PRIO: if (w_mem_starve && (wait_cnt_q == WAIT_LAST)) state_q <= MEM_PRIO;
            MEM_PRIO: if (!w_mem_nz || w_mem_grant) state_q <= ALU_PRIO;
            default:  state_q <= ALU_PRIO;
         endcase

         if (w_mem_starve) begin
            if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
         end else begin
            wait_cnt_q <= '0;
         end

         if (w_compete && (conflict_q != {CNT_W{1'b1}})) conflict_q <= conflict_q + 1'b1;

         // address/data/source hold when no write is issued
         wen_q <= w_alu_grant || w_mem_grant;
         if (w_mem_grant) begin
            addr_q <= mem_addr;
            data_q <= mem_data;
            src_q  <= WB_MEM;
         end else if (w_alu_grant) begin
            addr_q <= alu_addr;
            data_q <= alu_data;
            src_q  <= WB_ALU;
         end
      end
   end

   assign rf_write_en   = wen_q;
   assign rf_addr       = addr_q;
   assign rf_write_data = data_q;
   assign rf_src        = src_q;
   assign conflict_cnt  = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_write_arbiter : directed self-checking bench for rf_write_arbiter
// Rev 1.0
// ============================================================================
module tb_rf_write_arbiter;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned CW   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid;
   logic          alu_ready, mem_ready;
   logic [AW-1:0] alu_addr, mem_addr;
   logic [XLEN-1:0] alu_data, mem_data;
   logic          rf_write_en, rf_src;
   logic [AW-1:0] rf_addr;
   logic [XLEN-1:0] rf_write_data;
   logic [CW-1:0] conflict_cnt;
   logic [XLEN-1:0] regs [32];

   int checks   = 0;
   int failures = 0;

   rf_write_arbiter #(.XLEN(XLEN), .REG_ADDR_W(AW), .MAX_WAIT(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .rf_write_en(rf_write_en), .rf_addr(rf_addr), .rf_write_data(rf_write_data),
      .rf_src(rf_src), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // register file model fed by the arbiter's output stage
   always @(posedge clk) if (rf_write_en) regs[rf_addr] <= rf_write_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_alu(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      alu_valid = v; alu_addr = a; alu_data = d;
   endtask

   task automatic set_mem(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      mem_valid = v; mem_addr = a; mem_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_alu(1'b1, 5'd0, 32'h0);
      set_mem(1'b1, 5'd3, 32'h0);
      tick(); tick();
      check("rst_wen",      rf_write_en, 0);
      check("rst_addr",     rf_addr, 0);
      check("rst_data",     rf_write_data, 0);
      check("rst_src",      rf_src, 0);
      check("rst_cnt",      conflict_cnt, 0);
      check("rst_alu_rdy",  alu_ready, 0);
      check("rst_mem_rdy",  mem_ready, 0);
      set_alu(1'b0, 5'd0, 32'h0);
      set_mem(1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      tick();

      // lone ALU write
      set_alu(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("lone_alu_rdy", alu_ready, 1);
      check("lone_mem_rdy", mem_ready, 0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      check("lone_wen",  rf_write_en, 1);
      check("lone_addr", rf_addr, 5);
      check("lone_data", rf_write_data, 32'hDEADBEEF);
      check("lone_src",  rf_src, 0);
      tick();
      check("lone_rf_x5", regs[5], 32'hDEADBEEF);
      check("idle_wen",   rf_write_en, 0);
      check("idle_hold",  rf_addr, 5);

      // starvation: mem loses three times, wins the fourth
      set_mem(1'b1, 5'd7, 32'h1234);
      begin
         int k = 1;
         for (int cyc = 0; cyc < 12 && k <= 6; cyc++) begin
            logic exp_mem;
            exp_mem = (cyc == 3);
            set_alu(1'b1, AW'(k), XLEN'(100 + k));
            #1;
            check("starve_mem_rdy", mem_ready, exp_mem);
            check("starve_alu_rdy", alu_ready, !exp_mem);
            tick();
            if (exp_mem) begin
               set_mem(1'b0, 5'd0, 32'h0);
               check("starve_src",  rf_src, 1);
               check("starve_addr", rf_addr, 7);
               check("starve_data", rf_write_data, 32'h1234);
               check("starve_cnt",  conflict_cnt, 4);
            end else begin
               check("starve_alu_addr", rf_addr, k);
               check("starve_alu_src",  rf_src, 0);
               k++;
            end
         end
         check("starve_all_alu", k, 7);
      end
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check("starve_rf_x7",  regs[7], 32'h1234);
      check("starve_rf_x6",  regs[6], 106);
      check("starve_cnt_end", conflict_cnt, 4);

      // x0 sink: both accepted, only mem uses the port
      set_alu(1'b1, 5'd0, 32'hAAAA);
      set_mem(1'b1, 5'd9, 32'h55);
      #1;
      check("x0_alu_rdy", alu_ready, 1);
      check("x0_mem_rdy", mem_ready, 1);
      tick();
      set_mem(1'b0, 5'd0, 32'h0);
      check("x0_wen",  rf_write_en, 1);
      check("x0_addr", rf_addr, 9);
      check("x0_src",  rf_src, 1);
      check("x0_cnt",  conflict_cnt, 4);
      #1;
      check("x0_lone_rdy", alu_ready, 1);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      check("x0_lone_wen", rf_write_en, 0);
      check("x0_lone_hold", rf_addr, 9);

      // reach MEM_PRIO, then withdraw mem before it is granted
      set_alu(1'b1, 5'd1, 32'h11);
      set_mem(1'b1, 5'd2, 32'h22);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("prio_mem_lose", mem_ready, 0);
         tick();
      end
      set_mem(1'b0, 5'd0, 32'h0);
      #1;
      check("exit_alu_lone", alu_ready, 1);
      tick();
      set_mem(1'b1, 5'd3, 32'h33);
      #1;
      check("exit_alu_win", alu_ready, 1);
      check("exit_mem_lose", mem_ready, 0);
      tick();
      check("exit_src", rf_src, 0);
      check("exit_cnt", conflict_cnt, 8);

      // asynchronous reset between edges with both requesting
      #2;
      rst = 1'b1;
      #1;
      check("arst_wen",  rf_write_en, 0);
      check("arst_addr", rf_addr, 0);
      check("arst_data", rf_write_data, 0);
      check("arst_cnt",  conflict_cnt, 0);
      check("arst_alu_rdy", alu_ready, 0);
      check("arst_mem_rdy", mem_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_alu_rdy", alu_ready, 1);
      check("post_mem_rdy", mem_ready, 0);
      tick();
      check("post_src", rf_src, 0);
      check("post_addr", rf_addr, 1);
      check("post_cnt", conflict_cnt, 1);

      // saturation of the conflict counter
      set_alu(1'b1, 5'd4, 32'h44);
      set_mem(1'b1, 5'd8, 32'h88);
      for (int i = 0; i < 20; i++) tick();
      check("sat_cnt", conflict_cnt, 15);
      tick();
      check("sat_hold", conflict_cnt, 15);
      set_alu(1'b0, 5'd0, 32'h0);
      set_mem(1'b0, 5'd0, 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the single-cycle ALU path (source 0) and the long-latency load/mul-div path (source 1). Fixed ALU priority with a starvation guard for the memory path. Writes to x0 are dropped without using the port. The registered outputs drive the register file write port (write_en3/addr3/write_data3) directly.

Parameters:
XLEN, 32, data width of write data
REG_ADDR_W, 5, register address width
MAX_WAIT, 3, consecutive lost-arbitration cycles before source 1 is forced to win (legal range 1..15)
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU request accepted this cycle (combinational)
alu_addr  in  REG_ADDR_W  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load/mul-div write request
mem_ready  out  1  mem request accepted this cycle (combinational)
mem_addr  in  REG_ADDR_W  mem destination register
mem_data  in  XLEN  mem result
rf_write_en  out  1  registered write enable to register file
rf_addr  out  REG_ADDR_W  registered write address
rf_write_data  out  XLEN  registered write data
rf_src  out  1  registered source of current write (0 = ALU, 1 = mem)
conflict_cnt  out  CNT_W  saturating count of cycles with two competing non-x0 requests

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready. A requester holds valid, addr and data stable until accepted. ready may depend combinationally on valid. At most one non-x0 transfer per cycle.
- x0 sink: a request with addr == 0 gets ready=1 in the same cycle, independent of arbitration. It does not affect rf_write_en, the FSM or wait_cnt. Both sources may be accepted in one cycle if at least one targets x0.
- Competing: a cycle where both valids are high and both addrs are non-zero.
- FSM states:
  - ALU_PRIO (reset state): the ALU wins when competing.
  - MEM_PRIO: mem wins when competing.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments when mem has a non-x0 request pending and is not accepted.
  - Clears when mem is accepted, or when mem_valid is low or mem_addr is 0.
- Transitions:
  - ALU_PRIO -> MEM_PRIO when wait_cnt == MAX_WAIT-1 and it increments that cycle, so mem wins in the next competing cycle.
  - MEM_PRIO -> ALU_PRIO on a mem acceptance.
  - MEM_PRIO -> ALU_PRIO when mem_valid drops or targets x0; the FSM does not stay in MEM_PRIO.
- A lone non-x0 request is always accepted in the same cycle, in either state.
- Output latency: 1 cycle. If a non-x0 transfer happens at edge N, then after edge N rf_write_en=1 with the winner's addr, data and source. The register file commits at edge N+1. With no transfer, rf_write_en=0, and rf_addr/rf_write_data/rf_src hold their previous values.
- conflict_cnt increments by 1 on each competing cycle and saturates at 2^CNT_W-1. It never wraps.
- Reset (asynchronous, any time):
  - Values: rf_write_en=0, rf_addr=0, rf_write_data=0, rf_src=0, conflict_cnt=0, wait_cnt=0, FSM=ALU_PRIO.
  - alu_ready=mem_ready=0 while rst=1, including x0 requests.
  - A request in flight during reset is lost. The requester keeps valid asserted and is re-arbitrated after reset deasserts.
- The register file has no backpressure, so the output stage never stalls.

Decomposition:
- Shared package rf_pkg:
  - constants XLEN, REG_ADDR_W, REG_ZERO (5'd0)
  - typedef enum wb_src_e {WB_ALU, WB_MEM}
  - typedef enum arb_state_e {ALU_PRIO, MEM_PRIO}
  - typedef struct wb_req_t {valid, addr, data}
- No sub-module is needed; the FSM, counters and output register fit one module (~150 lines).

Test Plan:
- Lone ALU write: alu_valid=1, addr=5, data=32'hDEADBEEF for 1 cycle -> alu_ready=1 same cycle. Next cycle rf_write_en=1, rf_addr=5, rf_write_data=32'hDEADBEEF, rf_src=0. After one more edge, the register file reads x5 = DEADBEEF.
- Starvation, MAX_WAIT=3: ALU writes x1..x6 back-to-back while mem holds x7=32'h1234 -> mem_ready low for 3 cycles, high on the 4th (ALU stalled that cycle); conflict_cnt=4.
- x0 sink: alu addr=0 and mem addr=9, same cycle -> both ready=1; next cycle rf_write_en=1, rf_addr=9, rf_src=1. alu addr=0 alone -> rf_write_en stays 0.
- MEM_PRIO exit: reach MEM_PRIO, then drop mem_valid before a grant -> FSM returns to ALU_PRIO; a new conflict grants the ALU.
- Reset mid-operation: assert rst between clock edges while both request -> all outputs 0 immediately and readies 0. After release, ALU is granted first and conflict_cnt restarts from 0.
- Saturation, with CNT_W=4: 20 competing cycles -> conflict_cnt=15 and holds.
